// File: rtl/ps2_key_mapper.sv
// ps2_key_mapper: decodes PS/2 make/break/E0 scancode bytes into note, octave and ADSR controls.
// Latency: every output is registered and updates in the cycle after the strobe carrying the byte.
// Backpressure: none; one byte may be accepted on every clock and is never stalled or dropped.
//
// Ports:
//   clk, reset (async, active-low)  scan_code/scan_valid  byte input with a one-cycle strobe
//   note/note_in                    sounding note index and any-note-held flag
//   octave_plus_plus/minus_minus    one-cycle octave step pulses
//   ADSR_selector                   envelope parameter select (0..4)
//   ADSR_plus_plus/minus_minus      one-cycle parameter step pulses
// Build option: define ARROW_REPEAT_EN so typematic repeats of the up/down arrows
// keep pulsing ADSR_plus_plus/ADSR_minus_minus while the arrow is held.
module ps2_key_mapper #(
    parameter int unsigned SEL_DEFAULT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [3:0] note,
    output logic       note_in,
    output logic       octave_plus_plus,
    output logic       octave_minus_minus,
    output logic [2:0] ADSR_selector,
    output logic       ADSR_plus_plus,
    output logic       ADSR_minus_minus
);

    // Held-mask layout: bits 0..12 notes, then Z, X, up arrow, down arrow.
    localparam logic [4:0] K_Z    = 5'd13;
    localparam logic [4:0] K_X    = 5'd14;
    localparam logic [4:0] K_UP   = 5'd15;
    localparam logic [4:0] K_DN   = 5'd16;
    localparam logic [4:0] N_NOTE = 5'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] mask_q, mask_d;
    logic [3:0]  note_q, note_d;
    logic        note_in_q, note_in_d;
    logic [2:0]  sel_q, sel_d;
    logic        oct_pp_q, oct_pp_d;
    logic        oct_mm_q, oct_mm_d;
    logic        adsr_pp_q, adsr_pp_d;
    logic        adsr_mm_q, adsr_mm_d;

    logic        ext;
    logic        brk;
    logic        evt;
    logic        key_vld;
    logic [4:0]  key_idx;
    logic        sel_vld;
    logic [2:0]  sel_val;
    logic [12:0] rem_notes;
    logic [3:0]  low_note;

    // Prefix tracking; a prefix byte itself never produces an event.
    always_comb begin
        state_d = state_q;
        ext     = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        brk     = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        evt     = 1'b0;
        if (scan_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_code == 8'hE0)      state_d = ST_EXT;
                    else if (scan_code == 8'hF0) state_d = ST_BRK;
                    else                         evt     = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        evt     = 1'b1;
                    end
                end
                // After F0 the next byte is always the code, even a stray prefix value.
                ST_BRK, ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    evt     = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Key lookup: held-mask keys give key_idx, selector keys give sel_val.
    always_comb begin
        key_vld = 1'b0;
        key_idx = 5'd0;
        sel_vld = 1'b0;
        sel_val = 3'd0;
        if (ext) begin
            case (scan_code)
                8'h75:   begin key_vld = 1'b1; key_idx = K_UP; end
                8'h72:   begin key_vld = 1'b1; key_idx = K_DN; end
                default: ;
            endcase
        end else begin
            case (scan_code)
                8'h1C:   begin key_vld = 1'b1; key_idx = 5'd0;  end
                8'h1D:   begin key_vld = 1'b1; key_idx = 5'd1;  end
                8'h1B:   begin key_vld = 1'b1; key_idx = 5'd2;  end
                8'h24:   begin key_vld = 1'b1; key_idx = 5'd3;  end
                8'h23:   begin key_vld = 1'b1; key_idx = 5'd4;  end
                8'h2B:   begin key_vld = 1'b1; key_idx = 5'd5;  end
                8'h2C:   begin key_vld = 1'b1; key_idx = 5'd6;  end
                8'h34:   begin key_vld = 1'b1; key_idx = 5'd7;  end
                8'h35:   begin key_vld = 1'b1; key_idx = 5'd8;  end
                8'h33:   begin key_vld = 1'b1; key_idx = 5'd9;  end
                8'h3C:   begin key_vld = 1'b1; key_idx = 5'd10; end
                8'h3B:   begin key_vld = 1'b1; key_idx = 5'd11; end
                8'h42:   begin key_vld = 1'b1; key_idx = 5'd12; end
                8'h1A:   begin key_vld = 1'b1; key_idx = K_Z;   end
                8'h22:   begin key_vld = 1'b1; key_idx = K_X;   end
                8'h16:   begin sel_vld = 1'b1; sel_val = 3'd0;  end
                8'h1E:   begin sel_vld = 1'b1; sel_val = 3'd1;  end
                8'h26:   begin sel_vld = 1'b1; sel_val = 3'd2;  end
                8'h25:   begin sel_vld = 1'b1; sel_val = 3'd3;  end
                8'h2E:   begin sel_vld = 1'b1; sel_val = 3'd4;  end
                default: ;
            endcase
        end
    end

    // Notes still held once the current key is released; lowest index takes over.
    always_comb begin
        rem_notes = mask_q[12:0] & ~(13'd1 << key_idx);
        low_note  = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (rem_notes[i]) low_note = 4'(i);
        end
    end

    always_comb begin
        mask_d    = mask_q;
        note_d    = note_q;
        note_in_d = note_in_q;
        sel_d     = sel_q;
        oct_pp_d  = 1'b0;
        oct_mm_d  = 1'b0;
        adsr_pp_d = 1'b0;
        adsr_mm_d = 1'b0;
        if (evt) begin
            if (!brk) begin
                if (key_vld) begin
                    if (!mask_q[key_idx]) begin
                        mask_d[key_idx] = 1'b1;
                        if (key_idx < N_NOTE) begin
                            note_d    = key_idx[3:0];
                            note_in_d = 1'b1;
                        end
                        oct_mm_d  = (key_idx == K_Z);
                        oct_pp_d  = (key_idx == K_X);
                        adsr_pp_d = (key_idx == K_UP);
                        adsr_mm_d = (key_idx == K_DN);
                    end
`ifdef ARROW_REPEAT_EN
                    else begin
                        // Held arrows ramp the parameter on every typematic repeat.
                        adsr_pp_d = (key_idx == K_UP);
                        adsr_mm_d = (key_idx == K_DN);
                    end
`endif
                end
                if (sel_vld) sel_d = sel_val;
            end else if (key_vld && mask_q[key_idx]) begin
                mask_d[key_idx] = 1'b0;
                if ((key_idx < N_NOTE) && note_in_q && (key_idx[3:0] == note_q)) begin
                    // Releasing the sounding note falls back to the lowest held note;
                    // with none left the gate drops and the pitch is kept for release.
                    if (|rem_notes) note_d    = low_note;
                    else            note_in_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            note_q    <= 4'd0;
            note_in_q <= 1'b0;
            sel_q     <= 3'(SEL_DEFAULT);
            oct_pp_q  <= 1'b0;
            oct_mm_q  <= 1'b0;
            adsr_pp_q <= 1'b0;
            adsr_mm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            note_q    <= note_d;
            note_in_q <= note_in_d;
            sel_q     <= sel_d;
            oct_pp_q  <= oct_pp_d;
            oct_mm_q  <= oct_mm_d;
            adsr_pp_q <= adsr_pp_d;
            adsr_mm_q <= adsr_mm_d;
        end
    end

    assign note               = note_q;
    assign note_in            = note_in_q;
    assign ADSR_selector      = sel_q;
    assign octave_plus_plus   = oct_pp_q;
    assign octave_minus_minus = oct_mm_q;
    assign ADSR_plus_plus     = adsr_pp_q;
    assign ADSR_minus_minus   = adsr_mm_q;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// tb_ps2_key_mapper: directed scenarios plus a randomized key-event stream checked against
// a key-level reference model. Build with ARROW_REPEAT_EN defined to match that DUT variant.
module tb_ps2_key_mapper;

    localparam int unsigned SEL_DEF = 3;
`ifdef ARROW_REPEAT_EN
    localparam bit ARROW_RPT = 1'b1;
`else
    localparam bit ARROW_RPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic [3:0] note;
    logic       note_in;
    logic       octave_plus_plus;
    logic       octave_minus_minus;
    logic [2:0] ADSR_selector;
    logic       ADSR_plus_plus;
    logic       ADSR_minus_minus;

    int errors = 0;
    int checks = 0;

    // Pulse high-cycle counters, sampled at the falling edge.
    int n_op = 0, n_om = 0, n_ap = 0, n_am = 0;

    // Outputs captured one cycle after the most recent strobe.
    logic [3:0] cap_note;
    logic       cap_note_in;
    logic [2:0] cap_sel;
    logic [3:0] cap_pulse; // {op, om, ap, am}

    ps2_key_mapper #(.SEL_DEFAULT(SEL_DEF)) dut (
        .clk               (clk),
        .reset             (reset),
        .scan_code         (scan_code),
        .scan_valid        (scan_valid),
        .note              (note),
        .note_in           (note_in),
        .octave_plus_plus  (octave_plus_plus),
        .octave_minus_minus(octave_minus_minus),
        .ADSR_selector     (ADSR_selector),
        .ADSR_plus_plus    (ADSR_plus_plus),
        .ADSR_minus_minus  (ADSR_minus_minus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            n_op += int'(octave_plus_plus);
            n_om += int'(octave_minus_minus);
            n_ap += int'(ADSR_plus_plus);
            n_am += int'(ADSR_minus_minus);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model (key-event level) ----------------
    // Key table: 0..12 notes, 13 Z, 14 X, 15 up, 16 down, 17..21 selector 1-5, 22..23 unmapped.
    logic [7:0] k_code [24];
    bit         k_ext  [24];
    bit         m_held [17];
    int         m_note, m_note_in, m_sel;
    bit [3:0]   m_pulse;

    task automatic init_table();
        logic [7:0] codes [24] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                                   8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h1A, 8'h22, 8'h75,
                                   8'h72, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h5A, 8'h6B};
        for (int i = 0; i < 24; i++) begin
            k_code[i] = codes[i];
            k_ext[i]  = (i == 15) || (i == 16) || (i == 23);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 17; i++) m_held[i] = 1'b0;
        m_note = 0; m_note_in = 0; m_sel = SEL_DEF; m_pulse = 4'b0;
    endtask

    task automatic model_event(input int k, input bit is_brk);
        m_pulse = 4'b0;
        if (!is_brk) begin
            if (k >= 17 && k <= 21) m_sel = k - 17;
            else if (k < 17) begin
                if (!m_held[k]) begin
                    m_held[k] = 1'b1;
                    if (k < 13) begin m_note = k; m_note_in = 1; end
                    if (k == 14) m_pulse[3] = 1'b1;
                    if (k == 13) m_pulse[2] = 1'b1;
                    if (k == 15) m_pulse[1] = 1'b1;
                    if (k == 16) m_pulse[0] = 1'b1;
                end else if (ARROW_RPT) begin
                    if (k == 15) m_pulse[1] = 1'b1;
                    if (k == 16) m_pulse[0] = 1'b1;
                end
            end
        end else if (k < 17 && m_held[k]) begin
            m_held[k] = 1'b0;
            if (k < 13 && m_note_in == 1 && m_note == k) begin
                int low;
                low = -1;
                for (int i = 12; i >= 0; i--) if (m_held[i]) low = i;
                if (low >= 0) m_note = low;
                else          m_note_in = 0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input bit idle);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        cap_note    = note;
        cap_note_in = note_in;
        cap_sel     = ADSR_selector;
        cap_pulse   = {octave_plus_plus, octave_minus_minus, ADSR_plus_plus, ADSR_minus_minus};
        scan_valid  = 1'b0;
        if (idle) @(negedge clk);
    endtask

    task automatic apply_reset();
        scan_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++; if (note !== 4'd0) begin errors++; $display("FAIL reset_note got=%0d exp=0", note); end
        checks++; if (note_in !== 1'b0) begin errors++; $display("FAIL reset_note_in got=%b exp=0", note_in); end
        checks++; if (ADSR_selector !== 3'(SEL_DEF)) begin errors++; $display("FAIL reset_sel got=%0d exp=%0d", ADSR_selector, SEL_DEF); end
        checks++;
        if ({octave_plus_plus, octave_minus_minus, ADSR_plus_plus, ADSR_minus_minus} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses got=%b exp=0000",
                {octave_plus_plus, octave_minus_minus, ADSR_plus_plus, ADSR_minus_minus});
        end
    endtask

    task automatic test_note_basic();
        apply_reset();
        send_byte(8'h1C, 1'b1);
        checks++; if (cap_note !== 4'd0 || cap_note_in !== 1'b1) begin errors++; $display("FAIL note_make got=%0d/%b exp=0/1", cap_note, cap_note_in); end
        send_byte(8'hF0, 1'b1);
        send_byte(8'h1C, 1'b1);
        checks++; if (cap_note !== 4'd0 || cap_note_in !== 1'b0) begin errors++; $display("FAIL note_break got=%0d/%b exp=0/0", cap_note, cap_note_in); end
        // Gate drops but the last pitch is kept.
        send_byte(8'h42, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h42, 1'b1);
        checks++; if (cap_note !== 4'd12 || cap_note_in !== 1'b0) begin errors++; $display("FAIL note_hold got=%0d/%b exp=12/0", cap_note, cap_note_in); end
    endtask

    task automatic test_note_priority();
        apply_reset();
        send_byte(8'h1C, 1'b1);
        send_byte(8'h2B, 1'b1);
        checks++; if (cap_note !== 4'd5 || cap_note_in !== 1'b1) begin errors++; $display("FAIL prio_last got=%0d/%b exp=5/1", cap_note, cap_note_in); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h2B, 1'b1);
        checks++; if (cap_note !== 4'd0 || cap_note_in !== 1'b1) begin errors++; $display("FAIL prio_fallback got=%0d/%b exp=0/1", cap_note, cap_note_in); end
        send_byte(8'hF0, 1'b1);
        send_byte(8'h1C, 1'b1);
        checks++; if (cap_note_in !== 1'b0) begin errors++; $display("FAIL prio_all_up got=%b exp=0", cap_note_in); end
        // Lowest held note wins over the previously sounding one.
        send_byte(8'h2B, 1'b1);
        send_byte(8'h1C, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h3C, 1'b1);
        checks++; if (cap_note !== 4'd0) begin errors++; $display("FAIL prio_lowest got=%0d exp=0", cap_note); end
        send_byte(8'hF0, 1'b1);
        send_byte(8'h2B, 1'b1);
        checks++; if (cap_note !== 4'd0 || cap_note_in !== 1'b1) begin errors++; $display("FAIL prio_nonsounding got=%0d/%b exp=0/1", cap_note, cap_note_in); end
    endtask

    task automatic test_octave();
        int op0, om0;
        apply_reset();
        op0 = n_op; om0 = n_om;
        send_byte(8'h22, 1'b1);
        checks++; if (cap_pulse[3] !== 1'b1) begin errors++; $display("FAIL oct_first got=%b exp=1", cap_pulse[3]); end
        send_byte(8'h22, 1'b1);
        checks++; if (cap_pulse[3] !== 1'b0) begin errors++; $display("FAIL oct_repeat got=%b exp=0", cap_pulse[3]); end
        send_byte(8'hF0, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h22, 1'b1);
        checks++; if (n_op - op0 !== 2) begin errors++; $display("FAIL oct_plus_cycles got=%0d exp=2", n_op - op0); end
        send_byte(8'h1A, 1'b1);
        checks++; if (n_om - om0 !== 1) begin errors++; $display("FAIL oct_minus_cycles got=%0d exp=1", n_om - om0); end
    endtask

    task automatic test_adsr();
        int ap0, am0;
        apply_reset();
        ap0 = n_ap; am0 = n_am;
        send_byte(8'h26, 1'b1);
        checks++; if (cap_sel !== 3'd2) begin errors++; $display("FAIL sel_set got=%0d exp=2", cap_sel); end
        send_byte(8'hF0, 1'b1);
        send_byte(8'h26, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'h75, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'h75, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h75, 1'b1);
        checks++; if (ADSR_selector !== 3'd2) begin errors++; $display("FAIL sel_hold got=%0d exp=2", ADSR_selector); end
        checks++; if (n_ap - ap0 !== (ARROW_RPT ? 2 : 1)) begin errors++; $display("FAIL adsr_plus_count got=%0d exp=%0d", n_ap - ap0, ARROW_RPT ? 2 : 1); end
        send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b1);
        checks++; if (n_am - am0 !== 1) begin errors++; $display("FAIL adsr_minus_count got=%0d exp=1", n_am - am0); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_byte(8'h2E, 1'b1);
        send_byte(8'h1C, 1'b1);
        send_byte(8'hE0, 1'b1);
        send_byte(8'hF0, 1'b1);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (note_in !== 1'b0 || ADSR_selector !== 3'(SEL_DEF)) begin
            errors++; $display("FAIL async_reset got=%b/%0d exp=0/%0d", note_in, ADSR_selector, SEL_DEF);
        end
        #10 reset = 1'b1;
        @(negedge clk);
        send_byte(8'h1D, 1'b1);
        checks++;
        if (cap_note !== 4'd1 || cap_note_in !== 1'b1 || cap_sel !== 3'(SEL_DEF)) begin
            errors++; $display("FAIL reset_reparse got=%0d/%b/%0d exp=1/1/%0d", cap_note, cap_note_in, cap_sel, SEL_DEF);
        end
    endtask

    task automatic test_unmapped();
        int p0;
        apply_reset();
        send_byte(8'h25, 1'b1);
        send_byte(8'h2B, 1'b1);
        p0 = n_op + n_om + n_ap + n_am;
        send_byte(8'h5A, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'h6B, 1'b1);
        send_byte(8'hF0, 1'b1); send_byte(8'h77, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'h1C, 1'b1);
        send_byte(8'hF0, 1'b1); send_byte(8'hE0, 1'b1);
        checks++;
        if (cap_note !== 4'd5 || cap_note_in !== 1'b1 || cap_sel !== 3'd3) begin
            errors++; $display("FAIL unmapped_hold got=%0d/%b/%0d exp=5/1/3", cap_note, cap_note_in, cap_sel);
        end
        checks++; if (n_op + n_om + n_ap + n_am !== p0) begin errors++; $display("FAIL unmapped_pulses got=%0d exp=%0d", n_op + n_om + n_ap + n_am, p0); end
        send_byte(8'h1C, 1'b1);
        checks++; if (cap_note !== 4'd0 || cap_note_in !== 1'b1) begin errors++; $display("FAIL unmapped_idle got=%0d/%b exp=0/1", cap_note, cap_note_in); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [$];
        logic [11:0] got, exp;
        int k;
        bit is_brk;
        apply_reset();
        model_reset();
        for (int ev = 0; ev < 400; ev++) begin
            k = $urandom_range(0, 23);
            is_brk = ($urandom_range(0, 2) == 0);
            bytes.delete();
            if (k_ext[k]) bytes.push_back(8'hE0);
            if (is_brk)   bytes.push_back(8'hF0);
            bytes.push_back(k_code[k]);
            model_event(k, is_brk);
            for (int b = 0; b < bytes.size(); b++) begin
                send_byte(bytes[b], $urandom_range(0, 1) == 1);
                if (b != bytes.size() - 1) begin
                    checks++;
                    if (cap_pulse !== 4'b0) begin errors++; $display("FAIL rnd_prefix ev=%0d got=%b exp=0000", ev, cap_pulse); end
                end
            end
            got = {cap_note, cap_note_in, cap_sel, cap_pulse};
            exp = {4'(m_note), 1'(m_note_in), 3'(m_sel), m_pulse};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rnd_event ev=%0d key=%0d brk=%b got=%h exp=%h", ev, k, is_brk, got, exp);
            end
        end
    endtask

    initial begin
        init_table();
        test_reset();
        test_note_basic();
        test_note_priority();
        test_octave();
        test_adsr();
        test_reset_mid();
        test_unmapped();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
